s_acq_sel_nch: RTL

//  N-channel registered selector for acquisition control (load, reset, acq count, strip count).

---
 rtl/s_acq_pkg.sv | 18 +
 rtl/s_acq_chmux.sv | 34 +++
 rtl/s_acq_sel_nch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/s_acq_pkg.sv
// Shared state encoding and counter sizing for the N-channel acquisition selector.
package s_acq_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    localparam int DRAIN_MAX_DEF = 1023;
    localparam int RST_CYC_DEF   = 4;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/s_acq_chmux.sv
// Combinational N_CH-to-1 slice select of the packed per-channel control buses.
module s_acq_chmux #(
    parameter int N_CH    = 2,
    parameter int SEL_W   = 2,
    parameter int ACQ_W   = 16,
    parameter int STRIP_W = 12
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [N_CH-1:0]         load_i,
    input  logic [N_CH-1:0]         rst_i,
    input  logic [N_CH*ACQ_W-1:0]   acqnum_i,
    input  logic [N_CH*STRIP_W-1:0] stripnum_i,
    output logic                    load_o,
    output logic                    rst_o,
    output logic [ACQ_W-1:0]        acqnum_o,
    output logic [STRIP_W-1:0]      stripnum_o
);

    always_comb begin
        load_o     = 1'b0;
        rst_o      = 1'b0;
        acqnum_o   = '0;
        stripnum_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_i == SEL_W'(i)) begin
                load_o     = load_i[i];
                rst_o      = rst_i[i];
                acqnum_o   = acqnum_i[i*ACQ_W +: ACQ_W];
                stripnum_o = stripnum_i[i*STRIP_W +: STRIP_W];
            end
        end
    end

endmodule

// File: rtl/s_acq_sel_nch.sv
// Registered N-channel acquisition-control selector with drain-then-flush switchover.
module s_acq_sel_nch
    import s_acq_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int SEL_W     = 2,
    parameter int ACQ_W     = 16,
    parameter int STRIP_W   = 12,
    parameter int RST_CYC   = RST_CYC_DEF,
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic [SEL_W-1:0]        change_i,
    input  logic                    acq_busy_i,
    input  logic [N_CH-1:0]         s_loadin_i,
    input  logic [N_CH-1:0]         s_rstin_i,
    input  logic [N_CH*ACQ_W-1:0]   s_acqnumin_i,
    input  logic [N_CH*STRIP_W-1:0] s_stripnumin_i,
    output logic                    s_load_o,
    output logic                    s_rst_o,
    output logic [ACQ_W-1:0]        s_acqnum_o,
    output logic [STRIP_W-1:0]      s_stripnum_o,
    output logic [SEL_W-1:0]        active_ch_o,
    output logic                    switching_o,
    output logic                    sel_err_o,
    output logic                    drain_timeout_o
);

    localparam int DCW = cnt_w(DRAIN_MAX);
    localparam int FCW = cnt_w(RST_CYC);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   act_q, act_d, tgt_q, tgt_d;
    logic [DCW-1:0]     dcnt_q, dcnt_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;
    logic               load_q, load_d, rst_q, rst_d, err_q, err_d, to_q, to_d;
    logic [ACQ_W-1:0]   acq_q, acq_d;
    logic [STRIP_W-1:0] strip_q, strip_d;

    logic               mux_load, mux_rst;
    logic [ACQ_W-1:0]   mux_acq;
    logic [STRIP_W-1:0] mux_strip;
    logic               chg_vld;

    s_acq_chmux #(
        .N_CH   (N_CH),
        .SEL_W  (SEL_W),
        .ACQ_W  (ACQ_W),
        .STRIP_W(STRIP_W)
    ) u_chmux (
        .sel_i     (act_q),
        .load_i    (s_loadin_i),
        .rst_i     (s_rstin_i),
        .acqnum_i  (s_acqnumin_i),
        .stripnum_i(s_stripnumin_i),
        .load_o    (mux_load),
        .rst_o     (mux_rst),
        .acqnum_o  (mux_acq),
        .stripnum_o(mux_strip)
    );

    assign chg_vld = (int'(change_i) < N_CH);

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        tgt_d   = tgt_q;
        dcnt_d  = dcnt_q;
        fcnt_d  = fcnt_q;
        load_d  = mux_load;
        rst_d   = mux_rst;
        acq_d   = mux_acq;
        strip_d = mux_strip;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (!chg_vld) begin
                    err_d = 1'b1;
                end else if (change_i != act_q) begin
                    tgt_d   = change_i;
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                load_d  = 1'b0;
                rst_d   = rst_q;
                acq_d   = acq_q;
                strip_d = strip_q;
                if (!chg_vld) err_d = 1'b1;
                else          tgt_d = change_i;
                // Abort outranks both busy-low and timeout in the same cycle.
                if (chg_vld && change_i == act_q) begin
                    state_d = ST_ACTIVE;
                end else if (!acq_busy_i || dcnt_q == DCW'(DRAIN_MAX)) begin
                    to_d    = acq_busy_i;
                    act_d   = tgt_d;
                    fcnt_d  = '0;
                    state_d = ST_FLUSH;
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            ST_FLUSH: begin
                load_d = 1'b0;
                rst_d  = 1'b1;
                if (fcnt_q == FCW'(RST_CYC - 1)) state_d = ST_ACTIVE;
                else                             fcnt_d  = fcnt_q + FCW'(1);
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ACTIVE;
            act_q   <= '0;
            tgt_q   <= '0;
            dcnt_q  <= '0;
            fcnt_q  <= '0;
            load_q  <= 1'b0;
            rst_q   <= 1'b0;
            acq_q   <= '0;
            strip_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            tgt_q   <= tgt_d;
            dcnt_q  <= dcnt_d;
            fcnt_q  <= fcnt_d;
            load_q  <= load_d;
            rst_q   <= rst_d;
            acq_q   <= acq_d;
            strip_q <= strip_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign s_load_o        = load_q;
    assign s_rst_o         = rst_q;
    assign s_acqnum_o      = acq_q;
    assign s_stripnum_o    = strip_q;
    assign active_ch_o     = act_q;
    assign switching_o     = (state_q != ST_ACTIVE);
    assign sel_err_o       = err_q;
    assign drain_timeout_o = to_q;

endmodule
